// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, tick divider, mid-cell majority vote,
// parity/stop checking and a show-ahead output FIFO carrying per-word error flags.
module uart_rx_os #(
  parameter int CLK_DIV    = 27,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               rx,
  output logic [DATA_BITS-1:0]               rx_data,
  output logic                               parity_err,
  output logic                               frame_err,
  output logic                               rx_valid,
  input  logic                               rx_ready,
  output logic                               overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               busy
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = DATA_BITS + 2;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_A       = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_B       = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_C       = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          ODD_PAR   = (PARITY == 2);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_t;

  logic                 rx_meta, rxs;
  logic [DW-1:0]        div_cnt;
  logic                 tick;
  state_t               state;
  logic [SW-1:0]        s_cnt;
  logic                 smp_a, smp_b, vote;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 perr, ferr;
  logic                 push;
  logic [WW-1:0]        push_word;

  logic [WW-1:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 pop, full, wr_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                       div_cnt <= div_cnt + DW'(1);
  end

  assign tick = (div_cnt == DIV_LAST);
  // Two stored mid-cell samples plus the live one at the decision tick.
  assign vote = (smp_a & smp_b) | (smp_a & rxs) | (smp_b & rxs);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      s_cnt     <= '0;
      smp_a     <= 1'b0;
      smp_b     <= 1'b0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shift     <= '0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      push      <= 1'b0;
      push_word <= '0;
    end else begin
      push <= 1'b0;
      if (tick) begin
        if (state == ST_IDLE) begin
          if (!rxs) begin
            state    <= ST_START;
            s_cnt    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
          end
        end else begin
          s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + SW'(1);
          if (s_cnt == S_A) smp_a <= rxs;
          if (s_cnt == S_B) smp_b <= rxs;
          case (state)
            ST_START: begin
              if (s_cnt == S_C && vote) begin
                state <= ST_IDLE;
                s_cnt <= '0;
              end else if (s_cnt == S_LAST) begin
                state <= ST_DATA;
              end
            end
            ST_DATA: begin
              if (s_cnt == S_C) shift[bit_idx] <= vote;
              if (s_cnt == S_LAST) begin
                if (bit_idx == BIT_LAST) begin
                  bit_idx <= '0;
                  state   <= (PARITY != 0) ? ST_PAR : ST_STOP;
                end else begin
                  bit_idx <= bit_idx + IW'(1);
                end
              end
            end
            ST_PAR: begin
              if (s_cnt == S_C)    perr  <= ((^shift) ^ vote) != ODD_PAR;
              if (s_cnt == S_LAST) state <= ST_STOP;
            end
            ST_STOP: begin
              if (s_cnt == S_C) begin
                if (!vote) ferr <= 1'b1;
                // Leave mid stop bit so a start edge right after the frame is not missed.
                if (stop_idx == STOP_LAST) begin
                  push      <= 1'b1;
                  push_word <= {shift, perr, ferr | ~vote};
                  state     <= ST_IDLE;
                  s_cnt     <= '0;
                end
              end else if (s_cnt == S_LAST) begin
                stop_idx <= 1'b1;
              end
            end
            default: begin
              state <= ST_IDLE;
              s_cnt <= '0;
            end
          endcase
        end
      end
    end
  end

  assign rx_valid = (count != '0);
  assign pop      = rx_valid & rx_ready;
  assign full     = (count == FULL);
  assign wr_en    = push & (~full | pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pop)               overrun <= 1'b0;
      else if (push && full) overrun <= 1'b1;
    end
  end

  assign {rx_data, parity_err, frame_err} = mem[rd_ptr];
  assign fifo_count = count;
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os (8E1, fast divider): frames are serialised from a
// byte-level model, expected words queued at stimulus time and checked on every pop.
module tb_uart_rx_os;
  localparam int CLK_DIV = 4;
  localparam int OS      = 16;
  localparam int DB      = 8;
  localparam int PAR     = 1;
  localparam int SB      = 1;
  localparam int DEPTH   = 4;
  localparam int BP      = CLK_DIV * OS;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rx = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DB-1:0] rx_data;
  logic          parity_err, frame_err, rx_valid, overrun, busy;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;

  uart_rx_os #(
    .CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(DB),
    .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx),
    .rx_data(rx_data), .parity_err(parity_err), .frame_err(frame_err),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   rand_rdy = 1'b0;
  bit   exp_ovr  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BP) @(posedge clk);
    #1;
  endtask

  // Reference: even parity error when data XOR parity bit is odd; frame error when stop is low;
  // a completed word is lost if the FIFO already holds DEPTH unread words.
  task automatic send(input logic [7:0] d, input logic pbit, input logic stop_v, input int gap);
    exp_t e;
    e.d  = d;
    e.pe = ((^d) ^ pbit) != 1'b0;
    e.fe = ~stop_v;
    if (exp_q.size() >= DEPTH) exp_ovr = 1'b1;
    else                       exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(pbit);
    drive_bit(stop_v);
    repeat (gap) drive_bit(1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got %0h expected no word", rx_data);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", rx_data, e.d);
          check("pop_parity_err", parity_err, e.pe);
          check("pop_frame_err", frame_err, e.fe);
          exp_ovr = 1'b0;
        end
      end
    end
  end

  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : main
    logic [7:0] d;
    logic       pb, st;
    int         gap, waited;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data", rx_data, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Single clean frame held in the FIFO, then popped.
    send(8'hA5, 1'b0, 1'b1, 1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_valid", rx_valid, 1);
    check("a5_parity_err", parity_err, 0);
    check("a5_frame_err", frame_err, 0);
    check("a5_count", fifo_count, 1);
    check("a5_busy_idle", busy, 0);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("a5_valid_after_pop", rx_valid, 0);

    send(8'h03, 1'b1, 1'b1, 1);
    send(8'h03, 1'b0, 1'b1, 1);

    // Short low glitch: rejected by the start-bit vote.
    rx = 1'b0;
    repeat (4 * CLK_DIV) @(posedge clk);
    #1;
    check("glitch_busy_high", busy, 1);
    rx = 1'b1;
    repeat (2 * BP) @(posedge clk);
    #1;
    check("glitch_busy_low", busy, 0);
    check("glitch_count", fifo_count, 0);
    check("glitch_valid", rx_valid, 0);

    send(8'h5A, ^8'h5A, 1'b0, 2);
    send(8'h11, ^8'h11, 1'b1, 1);

    // Overflow: five back-to-back frames into a four-entry FIFO with no consumer.
    rx_ready = 1'b0;
    for (int v = 1; v <= 5; v++) send(8'(v), ^(8'(v)), 1'b1, 0);
    drive_bit(1'b1);
    check("ovf_count", fifo_count, DEPTH);
    check("ovf_overrun", overrun, exp_ovr);
    check("ovf_overrun_set", overrun, 1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovf_overrun_clear", overrun, 0);
    check("ovf_count_after_pop", fifo_count, DEPTH - 1);
    repeat (10) @(posedge clk);
    #1;
    check("ovf_drained", fifo_count, 0);

    // Reset in the middle of a frame discards both the FIFO and the partial word.
    rx_ready = 1'b0;
    send(8'h3C, ^8'h3C, 1'b1, 1);
    check("pre_reset_count", fifo_count, 1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rx = 1'b0;
    repeat (BP / 2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    exp_ovr = 1'b0;
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_flags", {parity_err, frame_err}, 0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2 * BP) @(posedge clk);
    #1;
    send(8'hC3, ^8'hC3, 1'b1, 1);
    check("c3_data", rx_data, 8'hC3);
    check("c3_count", fifo_count, 1);
    check("c3_parity_err", parity_err, 0);
    rx_ready = 1'b1;

    // Randomised frames with a randomly stalling consumer.
    rand_rdy = 1'b1;
    for (int n = 0; n < 20; n++) begin
      d   = 8'($urandom);
      pb  = 1'($urandom_range(0, 1));
      st  = ($urandom_range(0, 4) != 0);
      gap = st ? $urandom_range(0, 1) : 2;
      send(d, pb, st, gap);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    rx_ready = 1'b1;

    waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      @(posedge clk);
      waited++;
    end
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    check("final_count", fifo_count, 0);
    check("final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised oversampling UART receiver with frame-error detection and an output FIFO. Sits between the sensor UART pin and the command/decoding logic, replacing the fixed 8-bit, one-sample-per-bit receiver. It derives its own sample tick from the system clock and majority-votes each bit at mid-cell. Received words are buffered with per-word error flags behind a valid/ready interface.

## Interface
- CLK_DIV, 27: system clocks per sample tick (50 MHz / (115200·16) ≈ 27); ≥ 2
- OVERSAMPLE, 16: sample ticks per bit; even, ≥ 8
- DATA_BITS, 8: data bits per frame, 5..9, LSB first
- PARITY, 0: 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1: 1 or 2
- FIFO_DEPTH, 4: output FIFO entries, power of two, ≥ 2
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rx  in  1  serial line, idle high, asynchronous to clk
- rx_data  out  DATA_BITS  FIFO head word
- parity_err  out  1  parity mismatch for head word (0 when PARITY=0)
- frame_err  out  1  a stop bit of head word sampled low
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer pops head when rx_valid & rx_ready
- overrun  out  1  sticky: a completed frame was dropped, FIFO full
- fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied entries
- busy  out  1  receiver FSM not in IDLE

## Operation
- Async reset: all outputs 0; FIFO empty; FSM IDLE; both synchroniser flops 1; tick and sample counters 0.
- rx passes a 2-flop synchroniser; all decisions use the synchronised value rxs.
- Tick generator: free-running counter 0..CLK_DIV-1; tick is a one-clock pulse when counter = CLK_DIV-1.
- FSM states IDLE, START, DATA, PARITY, STOP; sample counter s advances 0..OVERSAMPLE-1 per tick, clear on state entry.
- Mid-cell vote: majority of rxs at ticks s = M-1, M, M+1 (M = OVERSAMPLE/2); bit decided at s = M+1.
- IDLE: on a tick with rxs = 0 → START, s = 0.
- START: vote = 1 → false start, back to IDLE, nothing pushed. Vote = 0 → DATA at s wrap.
- DATA: shift voted bit into bit position index (LSB first); after DATA_BITS bits → PARITY if PARITY≠0, else STOP.
- PARITY: perr = (XOR of data ^ voted bit) ≠ (PARITY==2); → STOP.
- STOP: each stop bit voted; any 0 sets ferr. At the last stop-bit decision: push {data, perr, ferr}; → IDLE immediately (mid stop bit) so the next start edge is caught with no gap.
- Frames with ferr (incl. break, all zeros) are still pushed.
- FIFO: show-ahead; rx_data/parity_err/frame_err reflect head, hold last popped value's slot contents don't matter when empty but are 0 after reset.
- Push and pop in the same cycle: both happen, count unchanged; allowed when full (pop frees slot).
- Push when full with no pop: frame dropped, contents unchanged, overrun ← 1. overrun clears on the next pop.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Bit period = CLK_DIV·OVERSAMPLE clocks.
- Start detection granularity: 1 tick + 2 sync clocks.
- Push occurs on the clock edge after the tick at s = M+1 of the last stop bit; rx_valid high the following cycle.
- Latency rx falling start edge → rx_valid ≈ (1 + DATA_BITS + (PARITY≠0) + STOP_BITS − 0.5)·bit period + 4 clocks max.
- Pop takes effect on the edge where rx_valid & rx_ready; new head visible next cycle.
- busy high from START entry to IDLE re-entry.
- reset_n low mid-frame aborts frame instantly; partial data discarded; first start edge after release received normally.
- Baud tolerance: ±3 % with OVERSAMPLE=16.

## Test plan
- 8N1, CLK_DIV=27: send 0xA5 → rx_data=0xA5, rx_valid=1, parity_err=0, frame_err=0, fifo_count=1; pop → rx_valid=0.
- PARITY=1: send 0x03 with parity bit 1 → parity_err=1, rx_data=0x03; with parity bit 0 → parity_err=0.
- rx low for 4 sample ticks then high → no push, busy returns 0, fifo_count=0.
- Stop bit driven 0 on 0x5A → rx_data=0x5A, frame_err=1; following 0x11 received clean.
- rx_ready=0, FIFO_DEPTH=4, send 0x01..0x05 back-to-back → fifo_count=4, overrun=1, pops yield 0x01..0x04; overrun 0 after first pop.
- reset_n pulsed low mid-data of a frame → all outputs 0; next frame 0xC3 received correctly.
